// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_if
// Description : Load/store request port, store-trace drain port and status
//               outputs shared between the core-side master and data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        bus_error;
  logic        log_valid;
  logic        log_ready;
  logic [3:0]  log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic [15:0] store_count;
  logic [15:0] load_count;

  modport master (
    output mem_read, mem_write, address, mem_write_data, log_ready,
    input  mem_read_data, bus_error, log_valid, log_addr, log_data,
           log_overflow, store_count, load_count
  );

  modport slave (
    input  mem_read, mem_write, address, mem_write_data, log_ready,
    output mem_read_data, bus_error, log_valid, log_addr, log_data,
           log_overflow, store_count, load_count
  );
endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : 16 x 32-bit word memory with combinational loads, clocked
//               stores, a store-trace FIFO with valid/ready drain, sticky
//               conflict/overflow flags and saturating load/store counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst,
  data_memory_if.slave  bus
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = $clog2(LOG_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOG_DEPTH);

  logic [31:0]      mem_q       [DEPTH];
  logic [31:0]      mem_d       [DEPTH];
  logic [3:0]       fifo_addr_q [LOG_DEPTH];
  logic [3:0]       fifo_addr_d [LOG_DEPTH];
  logic [31:0]      fifo_data_q [LOG_DEPTH];
  logic [31:0]      fifo_data_d [LOG_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bus_error_q, bus_error_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      store_count_q, store_count_d;
  logic [15:0]      load_count_q, load_count_d;

  logic is_load, is_store, is_conflict;
  logic fifo_empty, fifo_full, do_pop, do_push;

  // Classify the request and decide FIFO push/pop; a push into a full FIFO
  // is only accepted when the head leaves in the same cycle.
  always_comb begin
    is_load     = bus.mem_read & ~bus.mem_write;
    is_store    = bus.mem_write & ~bus.mem_read;
    is_conflict = bus.mem_read & bus.mem_write;
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FULL_CNT);
    do_pop      = ~fifo_empty & bus.log_ready;
    do_push     = is_store & (~fifo_full | do_pop);
  end

  // Next-state computation for memory, trace FIFO, flags and counters.
  always_comb begin
    mem_d         = mem_q;
    fifo_addr_d   = fifo_addr_q;
    fifo_data_d   = fifo_data_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    bus_error_d   = bus_error_q | is_conflict;
    overflow_d    = overflow_q | (is_store & ~do_push);
    store_count_d = store_count_q;
    load_count_d  = load_count_q;

    if (is_store) begin
      mem_d[bus.address] = bus.mem_write_data;
      if (store_count_q != 16'hFFFF) store_count_d = store_count_q + 16'd1;
    end
    if (is_load && load_count_q != 16'hFFFF) load_count_d = load_count_q + 16'd1;

    if (do_push) begin
      fifo_addr_d[wr_ptr_q] = bus.address;
      fifo_data_d[wr_ptr_q] = bus.mem_write_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears everything immediately, independent of clock.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      bus_error_q   <= 1'b0;
      overflow_q    <= 1'b0;
      store_count_q <= '0;
      load_count_q  <= '0;
    end else begin
      mem_q         <= mem_d;
      fifo_addr_q   <= fifo_addr_d;
      fifo_data_q   <= fifo_data_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      bus_error_q   <= bus_error_d;
      overflow_q    <= overflow_d;
      store_count_q <= store_count_d;
      load_count_q  <= load_count_d;
    end
  end

  // Loads read the pre-edge contents, so a store is visible from the next cycle.
  assign bus.mem_read_data = is_load ? mem_q[bus.address] : 32'h0;
  assign bus.log_valid     = ~fifo_empty;
  assign bus.log_addr      = fifo_empty ? 4'h0  : fifo_addr_q[rd_ptr_q];
  assign bus.log_data      = fifo_empty ? 32'h0 : fifo_data_q[rd_ptr_q];
  assign bus.bus_error     = bus_error_q;
  assign bus.log_overflow  = overflow_q;
  assign bus.store_count   = store_count_q;
  assign bus.load_count    = load_count_q;

endmodule
`default_nettype wire
